// File: rtl/bus_receiver.sv
// bus_receiver: receive end of the shared tri-state CPU bus.
//   Samples BusWires into a bank of NREG general registers under one-hot
//   load enables (Rin). Every accepted load is also recorded as {idx,data}
//   in a small first-word-fall-through snoop FIFO, which a trace consumer
//   drains with a valid/ready handshake. The block only reads the bus.
// Ports:
//   Clock, Resetn          rising-edge clock, async active-low reset
//   BusWires               bus value, sampled on load
//   Rin                    one-hot register load enables
//   rd_sel / rd_data       combinational register read-back
//   err_multi / err_count  multi-hot Rin pulse and saturating event count
//   log_valid/ready/idx/data  FIFO head and handshake
//   log_level              FIFO occupancy 0..LOGD
//   log_ovf / ovf_clr      sticky overflow flag and its clear
module bus_receiver #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8,
  parameter int IDXW  = 3,
  parameter int LOGD  = 4
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [WIDTH-1:0]        BusWires,
  input  logic [NREG-1:0]         Rin,
  input  logic [IDXW-1:0]         rd_sel,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    err_multi,
  output logic [7:0]              err_count,
  output logic                    log_valid,
  input  logic                    log_ready,
  output logic [IDXW-1:0]         log_idx,
  output logic [WIDTH-1:0]        log_data,
  output logic [$clog2(LOGD):0]   log_level,
  output logic                    log_ovf,
  input  logic                    ovf_clr
);
  localparam int PW = $clog2(LOGD);
  localparam int LW = PW + 1;
  localparam int EW = IDXW + WIDTH;

  // Load decode: x & (x-1) is nonzero exactly when more than one bit is set.
  logic            multi, onehot;
  logic [IDXW-1:0] load_idx;

  assign multi  = |(Rin & (Rin - NREG'(1)));
  assign onehot = (|Rin) & ~multi;

  always_comb begin
    load_idx = '0;
    for (int i = 0; i < NREG; i++)
      if (Rin[i]) load_idx = IDXW'(i);
  end

  // Register bank, one flop group per register.
  logic [NREG-1:0][WIDTH-1:0] regs;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)                regs[g] <= '0;
      else if (onehot && Rin[g])  regs[g] <= BusWires;
    end
  end

  assign rd_data = regs[rd_sel];

  // Multi-hot error reporting.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      err_multi <= 1'b0;
      err_count <= '0;
    end else begin
      err_multi <= multi;
      if (multi && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Snoop FIFO. Storage is not reset; the head is masked while empty so
  // log_idx/log_data read zero after reset.
  logic [EW-1:0] mem [LOGD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push, ovf_set;
  logic [EW-1:0] head;

  assign log_valid = (log_level != '0);
  assign full      = (log_level == LW'(LOGD));
  assign pop       = log_valid & log_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push      = onehot & (~full | pop);
  assign ovf_set   = onehot & full & ~pop;

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {load_idx, BusWires};
  end

  assign head     = mem[rd_ptr];
  assign log_idx  = log_valid ? head[EW-1:WIDTH] : '0;
  assign log_data = log_valid ? head[WIDTH-1:0]  : '0;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_level <= '0;
      log_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   log_level <= log_level + LW'(1);
        2'b01:   log_level <= log_level - LW'(1);
        default: log_level <= log_level;
      endcase
      // Set has priority over clear.
      if (ovf_set)      log_ovf <= 1'b1;
      else if (ovf_clr) log_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_receiver.sv
module tb_bus_receiver;
  logic       Clock = 1'b0;
  logic       Resetn;
  logic [7:0] BusWires;
  logic [7:0] Rin;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic       err_multi;
  logic [7:0] err_count;
  logic       log_valid;
  logic       log_ready;
  logic [2:0] log_idx;
  logic [7:0] log_data;
  logic [2:0] log_level;
  logic       log_ovf;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  bus_receiver #(.WIDTH(8), .NREG(8), .IDXW(3), .LOGD(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .BusWires(BusWires), .Rin(Rin),
    .rd_sel(rd_sel), .rd_data(rd_data), .err_multi(err_multi),
    .err_count(err_count), .log_valid(log_valid), .log_ready(log_ready),
    .log_idx(log_idx), .log_data(log_data), .log_level(log_level),
    .log_ovf(log_ovf), .ovf_clr(ovf_clr)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load one register; inputs return idle afterwards.
  task automatic load(input int r, input logic [7:0] v);
    Rin = 8'(1 << r);
    BusWires = v;
    tick();
    Rin = '0;
  endtask

  initial begin
    Resetn = 1'b0; BusWires = '0; Rin = '0; rd_sel = '0;
    log_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    @(negedge Clock); Resetn = 1'b1;
    tick();

    // ---- Reset ----
    rd_sel = 3'd3;
    load(3, 8'h5A);
    chk("r3_loaded", rd_data, 8'h5A);
    chk("pre_rst_valid", log_valid, 1'b1);
    #2 Resetn = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_valid", log_valid, 1'b0);
    chk("rst_level", log_level, 3'd0);
    chk("rst_errcnt", err_count, 8'd0);
    chk("rst_log_data", log_data, 8'h00);
    chk("rst_ovf", log_ovf, 1'b0);
    @(negedge Clock); Resetn = 1'b1;
    tick();

    // ---- Single load + read-back ----
    rd_sel = 3'd2; BusWires = 8'hA5; Rin = 8'b0000_0100;
    #1;
    chk("read_old_before_edge", rd_data, 8'h00);
    tick(); Rin = '0;
    chk("rd_r2", rd_data, 8'hA5);
    chk("single_valid", log_valid, 1'b1);
    chk("single_idx", log_idx, 3'd2);
    chk("single_data", log_data, 8'hA5);
    chk("single_level", log_level, 3'd1);
    log_ready = 1'b1; tick(); log_ready = 1'b0;
    chk("single_drained", log_level, 3'd0);
    chk("single_valid0", log_valid, 1'b0);

    // ---- Multi-hot ----
    log_ready = 1'b1;              // FIFO drains as fast as it fills
    load(0, 8'h11);
    load(4, 8'h44);
    tick();
    chk("pre_multi_level", log_level, 3'd0);
    Rin = 8'b0001_0001; BusWires = 8'hFF;
    tick(); Rin = '0;
    chk("multi_pulse", err_multi, 1'b1);
    chk("multi_count", err_count, 8'd1);
    chk("multi_no_push", log_level, 3'd0);
    rd_sel = 3'd0; #1;
    chk("multi_r0", rd_data, 8'h11);
    rd_sel = 3'd4; #1;
    chk("multi_r4", rd_data, 8'h44);
    tick();
    chk("multi_pulse_end", err_multi, 1'b0);
    chk("ready_empty_level", log_level, 3'd0);
    log_ready = 1'b0;
    Rin = 8'b0001_0001;
    for (int i = 0; i < 299; i++) tick();
    Rin = '0;
    chk("multi_sat", err_count, 8'd255);
    tick();
    chk("multi_sat_hold", err_count, 8'd255);

    // ---- Overflow ----
    for (int i = 1; i <= 5; i++) load(i, 8'(i));
    chk("ovf_level", log_level, 3'd4);
    chk("ovf_flag", log_ovf, 1'b1);
    rd_sel = 3'd5; #1;
    chk("ovf_r5", rd_data, 8'h05);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", log_ovf, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain_idx", log_idx, 32'(k));
      chk("ovf_drain_data", log_data, 32'(k));
      log_ready = 1'b1; tick(); log_ready = 1'b0;
    end
    chk("ovf_drained", log_level, 3'd0);

    // ---- Full with simultaneous push/pop ----
    load(1, 8'h11); load(2, 8'h22); load(3, 8'h33); load(4, 8'h44);
    chk("full_level", log_level, 3'd4);
    Rin = 8'b1000_0000; BusWires = 8'h77; log_ready = 1'b1;
    tick(); Rin = '0; log_ready = 1'b0;
    chk("pp_no_ovf", log_ovf, 1'b0);
    chk("pp_level", log_level, 3'd4);
    chk("pp_head_idx", log_idx, 3'd2);
    chk("pp_head_data", log_data, 8'h22);
    begin
      logic [2:0] ei [4];
      logic [7:0] ed [4];
      ei = '{3'd2, 3'd3, 3'd4, 3'd7};
      ed = '{8'h22, 8'h33, 8'h44, 8'h77};
      for (int k = 0; k < 4; k++) begin
        chk("wrap_idx", log_idx, ei[k]);
        chk("wrap_data", log_data, ed[k]);
        log_ready = 1'b1; tick(); log_ready = 1'b0;
      end
    end
    chk("wrap_empty", log_valid, 1'b0);

    // ---- Overflow set wins over clear ----
    load(1, 8'hA1); load(2, 8'hA2); load(3, 8'hA3); load(4, 8'hA4);
    Rin = 8'b0010_0000; BusWires = 8'h99; ovf_clr = 1'b1;
    tick(); Rin = '0; ovf_clr = 1'b0;
    chk("set_wins", log_ovf, 1'b1);
    chk("set_wins_level", log_level, 3'd4);
    rd_sel = 3'd5; #1;
    chk("drop_still_loads", rd_data, 8'h99);
    log_ready = 1'b1; tick(); log_ready = 1'b0;
    chk("mid_level3", log_level, 3'd3);

    // ---- Reset mid-drain ----
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rst_valid", log_valid, 1'b0);
    chk("mid_rst_level", log_level, 3'd0);
    chk("mid_rst_ovf", log_ovf, 1'b0);
    @(negedge Clock); Resetn = 1'b1;
    tick();
    load(6, 8'h3C);
    chk("post_rst_valid", log_valid, 1'b1);
    chk("post_rst_idx", log_idx, 3'd6);
    chk("post_rst_data", log_data, 8'h3C);
    chk("post_rst_level", log_level, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
